// File: rtl/hall_call_scheduler.sv
// Hall-call buffer: latches legal up/down hall presses into per-floor pending
// bits, drives the lamps, and hands one pending call to the car FSM per done.
// MODE 0 dispatches by fixed priority; MODE 1 uses a direction-aware SCAN.
module hall_call_scheduler #(
  parameter int unsigned FLOORS = 4,
  parameter int unsigned MODE   = 1,
  localparam int unsigned FW    = $clog2(FLOORS),
  localparam int unsigned CW    = $clog2(2 * FLOORS - 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic [FW-1:0]     req_floor_i,
  input  logic              req_dir_i,
  input  logic              clr_all_i,
  input  logic              done_i,
  input  logic [FW-1:0]     cur_floor_i,
  input  logic              cur_dir_i,
  output logic              sel_valid_o,
  output logic [FW-1:0]     sel_floor_o,
  output logic              sel_dir_o,
  output logic [FLOORS-1:0] up_lamp_o,
  output logic [FLOORS-1:0] dn_lamp_o,
  output logic [CW-1:0]     pend_cnt_o,
  output logic              empty_o,
  output logic              req_err_o
);

  localparam int NF = int'(FLOORS);
  localparam int NI = 1 << FW;

  logic [FLOORS-1:0] up_q, up_d, dn_q, dn_d;
  logic              sel_valid_q, sel_valid_d;
  logic [FW-1:0]     sel_floor_q, sel_floor_d;
  logic              sel_dir_q, sel_dir_d;
  logic              req_err_q, req_err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NI-1:0]     floor_ok;
  logic [FLOORS-1:0] ge_mask, le_mask;
  logic [FLOORS-1:0] req_oh, pick_oh;
  logic              req_legal;
  logic              pick_hit;
  logic [FW-1:0]     pick_floor;
  logic              pick_dir;

  // Index of the lowest set bit (caller guarantees v is non-zero).
  function automatic logic [FW-1:0] low_idx(input logic [FLOORS-1:0] v);
    low_idx = '0;
    for (int i = NF - 1; i >= 0; i--) begin
      if (v[i]) low_idx = FW'(i);
    end
  endfunction

  // Index of the highest set bit (caller guarantees v is non-zero).
  function automatic logic [FW-1:0] high_idx(input logic [FLOORS-1:0] v);
    high_idx = '0;
    for (int i = 0; i < NF; i++) begin
      if (v[i]) high_idx = FW'(i);
    end
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [FLOORS-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NF; i++) popcnt = popcnt + CW'(v[i]);
  endfunction

  // Floor-range table and SCAN masks relative to the car position.
  always_comb begin
    floor_ok = '0;
    ge_mask  = '0;
    le_mask  = '0;
    for (int i = 0; i < NI; i++) floor_ok[i] = (i < NF);
    for (int i = 0; i < NF; i++) begin
      ge_mask[i] = (FW'(i) >= cur_floor_i);
      le_mask[i] = (FW'(i) <= cur_floor_i);
    end
  end

  // Request legality and one-hot decode of the pressed floor.
  always_comb begin
    req_oh    = {{(FLOORS - 1){1'b0}}, 1'b1} << req_floor_i;
    req_legal = req_valid_i && floor_ok[req_floor_i]
                && !(!req_dir_i && (req_floor_i == FW'(NF - 1)))
                && !(req_dir_i && (req_floor_i == '0));
  end

  // Dispatch policy, evaluated on the registered pending state only.
  always_comb begin
    pick_hit   = (|up_q) || (|dn_q);
    pick_floor = '0;
    pick_dir   = 1'b0;
    if (MODE == 0) begin
      if (|up_q) begin
        pick_floor = low_idx(up_q);
      end else begin
        pick_floor = low_idx(dn_q);
        pick_dir   = 1'b1;
      end
    end else if (!cur_dir_i) begin
      if (|(up_q & ge_mask)) begin
        pick_floor = low_idx(up_q & ge_mask);
      end else if (|dn_q) begin
        pick_floor = high_idx(dn_q);
        pick_dir   = 1'b1;
      end else begin
        pick_floor = low_idx(up_q);
      end
    end else begin
      if (|(dn_q & le_mask)) begin
        pick_floor = high_idx(dn_q & le_mask);
        pick_dir   = 1'b1;
      end else if (|up_q) begin
        pick_floor = low_idx(up_q);
      end else begin
        pick_floor = high_idx(dn_q);
        pick_dir   = 1'b1;
      end
    end
    pick_oh = {{(FLOORS - 1){1'b0}}, 1'b1} << pick_floor;
  end

  // Next state: flush beats everything; clear of the dispatched bit happens
  // before the new press so a same-edge set of that bit wins.
  always_comb begin
    up_d        = up_q;
    dn_d        = dn_q;
    sel_valid_d = 1'b0;
    sel_floor_d = sel_floor_q;
    sel_dir_d   = sel_dir_q;
    req_err_d   = 1'b0;
    if (clr_all_i) begin
      up_d = '0;
      dn_d = '0;
    end else begin
      if (done_i && pick_hit) begin
        sel_valid_d = 1'b1;
        sel_floor_d = pick_floor;
        sel_dir_d   = pick_dir;
        if (pick_dir) dn_d = dn_d & ~pick_oh;
        else          up_d = up_d & ~pick_oh;
      end
      if (req_legal) begin
        if (req_dir_i) dn_d = dn_d | req_oh;
        else           up_d = up_d | req_oh;
      end else if (req_valid_i) begin
        req_err_d = 1'b1;
      end
    end
    cnt_d = popcnt(up_d) + popcnt(dn_d);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      up_q        <= '0;
      dn_q        <= '0;
      sel_valid_q <= 1'b0;
      sel_floor_q <= '0;
      sel_dir_q   <= 1'b0;
      req_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      up_q        <= up_d;
      dn_q        <= dn_d;
      sel_valid_q <= sel_valid_d;
      sel_floor_q <= sel_floor_d;
      sel_dir_q   <= sel_dir_d;
      req_err_q   <= req_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign sel_valid_o = sel_valid_q;
  assign sel_floor_o = sel_floor_q;
  assign sel_dir_o   = sel_dir_q;
  assign up_lamp_o   = up_q;
  assign dn_lamp_o   = dn_q;
  assign pend_cnt_o  = cnt_q;
  assign empty_o     = (cnt_q == '0);
  assign req_err_o   = req_err_q;

endmodule
